// File: rtl/inst_fetch_resp.sv
// inst_fetch_resp: instruction-fetch responder sitting between the PC register
// and decode. It turns each enabled PC into a read of the synchronous
// instruction ROM. Returned words are held in a small FIFO together with their
// PCs and handed to decode over a valid/ready handshake. It stalls the PC
// register whenever the FIFO could not absorb another in-flight word, and it
// discards wrong-path fetches on flush.
//
// Optional feature: define IF_ALIGN_CHECK_EN to flag misaligned PCs.
// A misaligned entry is then delivered with inst_fault=1 and inst_out=0.
// Without the macro, inst_fault is tied low and pc[1:0] never affects data.

module inst_fetch_resp #(
    parameter int ADDR_WIDTH = 14,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  chip_enable,
    input  logic                  flush,
    output logic                  stall,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-3:0] rom_addr,
    input  logic [31:0]           rom_data,
    output logic                  inst_valid,
    output logic [31:0]           inst_out,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_fault,
    input  logic                  id_ready
);

    // Occupancy plus one in-flight word reaches DEPTH+1, so this width never wraps.
    localparam int CW = $clog2(DEPTH + 2);
    localparam int PW = $clog2(DEPTH);

    logic [CW-1:0]         count;
    logic                  inflight;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [ADDR_WIDTH-1:0] pending_pc;

    logic [31:0]           mem_data [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_pc   [DEPTH];

    logic                  head_fault;
    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [CW-1:0]         occupancy;
    logic [CW-1:0]         stall_limit;

`ifdef IF_ALIGN_CHECK_EN
    logic                  pending_fault;
    logic                  mem_fault [DEPTH];
`endif

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // "count + inflight - pop >= DEPTH" is rewritten as a comparison against
    // DEPTH + pop, so there is no subtraction that could underflow.
    assign occupancy   = count + CW'(inflight);
    assign stall_limit = CW'(DEPTH) + CW'(pop);

    // Reset gates every handshake output low, so nothing leaks out of a
    // FIFO whose state has not been cleared yet.
    assign inst_valid = ~rst & (count != '0);
    assign pop        = inst_valid & id_ready & ~flush;
    assign stall      = ~rst & ~flush & (occupancy >= stall_limit);
    assign issue      = ~rst & chip_enable & ~stall & ~flush;
    assign push       = ~rst & inflight & ~flush;

    assign rom_en   = issue;
    assign rom_addr = pc[ADDR_WIDTH-1:2];

`ifdef IF_ALIGN_CHECK_EN
    assign head_fault = mem_fault[rd_ptr];
`else
    assign head_fault = 1'b0;
`endif

    // A faulted head never exposes ROM data.
    // An empty FIFO presents all-zero outputs.
    assign inst_fault = inst_valid & head_fault;
    assign inst_out   = (inst_valid & ~head_fault) ? mem_data[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? mem_pc[rd_ptr] : '0;

    // Control state: occupancy, pointers and the single in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            inflight   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pending_pc <= '0;
`ifdef IF_ALIGN_CHECK_EN
            pending_fault <= 1'b0;
`endif
        end else if (flush) begin
            count    <= '0;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pending_pc <= pc;
`ifdef IF_ALIGN_CHECK_EN
                pending_fault <= (pc[1:0] != 2'b00);
`endif
            end
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // FIFO storage is written at the tail when a ROM word returns on the correct path.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= rom_data;
            mem_pc[wr_ptr]   <= pending_pc;
`ifdef IF_ALIGN_CHECK_EN
            mem_fault[wr_ptr] <= pending_fault;
`endif
        end
    end

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Testbench for inst_fetch_resp.
// It drives directed scenarios and then a randomized run, and checks every
// cycle against a queue-based model of the fetch buffer.

module tb_inst_fetch_resp;

    localparam int AW    = 14;
    localparam int DEPTH = 2;

`ifdef IF_ALIGN_CHECK_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [AW-1:0] pc;
    logic          chip_enable;
    logic          flush;
    logic          stall;
    logic          rom_en;
    logic [AW-3:0] rom_addr;
    logic [31:0]   rom_data;
    logic          inst_valid;
    logic [31:0]   inst_out;
    logic [AW-1:0] inst_pc;
    logic          inst_fault;
    logic          id_ready;

    inst_fetch_resp #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .pc(pc),
        .chip_enable(chip_enable),
        .flush(flush),
        .stall(stall),
        .rom_en(rom_en),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .inst_valid(inst_valid),
        .inst_out(inst_out),
        .inst_pc(inst_pc),
        .inst_fault(inst_fault),
        .id_ready(id_ready)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM contents are a fixed function of the word address
    function automatic logic [31:0] rom_word(input logic [AW-3:0] a);
        return ({20'h0, a} * 32'h9E37_79B1) + 32'h0BAD_F00D;
    endfunction

    // Synchronous ROM with one cycle of read latency
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_word(rom_addr);
    end

    // Reference model: PCs waiting in the buffer, plus the outstanding request
    logic [AW-1:0] model_q[$];
    bit            model_inflight;
    logic [AW-1:0] model_pending;

    int            checks_done;
    int            fail_count;

    // Per-phase statistics and the most recent observations
    int            delivered;
    int            issued;
    int            stall_cycles;
    logic [AW-1:0] first_pop_pc;
    logic [AW-1:0] last_pop_pc;
    logic [AW-1:0] dropped_pc;
    int            seen_dropped;
    bit            issued_now;
    bit            obs_valid;
    bit            obs_fault;
    logic [31:0]   obs_out;
    logic [AW-1:0] pc_reg;

    // Comparison helper: counts the check and reports any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_done++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive the inputs, check the outputs against the model, then advance the model
    task automatic applyStimulus(input bit r, input bit ce, input logic [AW-1:0] p,
                                 input bit fl, input bit rdy);
        bit          exp_valid;
        bit          exp_pop;
        bit          exp_stall;
        bit          exp_en;
        bit          exp_fault;
        logic [AW-1:0] hpc;
        logic [31:0] exp_out;
        int          occ;
        @(negedge clk);
        rst         = r;
        chip_enable = ce;
        pc          = p;
        flush       = fl;
        id_ready    = rdy;
        #1;
        occ       = model_q.size() + (model_inflight ? 1 : 0);
        exp_valid = !r && (model_q.size() > 0);
        exp_pop   = exp_valid && rdy && !fl;
        exp_stall = !r && !fl && ((occ - (exp_pop ? 1 : 0)) >= DEPTH);
        exp_en    = !r && ce && !exp_stall && !fl;
        hpc       = exp_valid ? model_q[0] : '0;
        exp_fault = exp_valid && ALIGN_ON && (hpc[1:0] != 2'b00);
        exp_out   = (exp_valid && !exp_fault) ? rom_word(hpc[AW-1:2]) : 32'h0;

        checkOutput("stall",      32'(stall),      32'(exp_stall));
        checkOutput("rom_en",     32'(rom_en),     32'(exp_en));
        checkOutput("rom_addr",   32'(rom_addr),   32'(p[AW-1:2]));
        checkOutput("inst_valid", 32'(inst_valid), 32'(exp_valid));
        checkOutput("inst_pc",    32'(inst_pc),    32'(hpc));
        checkOutput("inst_out",   inst_out,        exp_out);
        checkOutput("inst_fault", 32'(inst_fault), 32'(exp_fault));

        obs_valid  = inst_valid;
        obs_fault  = inst_fault;
        obs_out    = inst_out;
        issued_now = rom_en;
        if (rom_en) issued++;
        if (stall) stall_cycles++;
        if (!r && !fl && rdy && inst_valid) begin
            if (delivered == 0) first_pop_pc = inst_pc;
            delivered++;
            last_pop_pc = inst_pc;
            if (inst_pc == dropped_pc) seen_dropped++;
        end

        @(posedge clk);
        if (r || fl) begin
            model_q.delete();
            model_inflight = 1'b0;
        end else begin
            if (exp_pop) void'(model_q.pop_front());
            if (model_inflight) model_q.push_back(model_pending);
            model_inflight = exp_en;
            if (exp_en) model_pending = p;
        end
    endtask

    // Behaves like the PC register: advances by 4 only when the fetch issued
    task automatic stepPc(input bit ce, input bit rdy);
        applyStimulus(1'b0, ce, pc_reg, 1'b0, rdy);
        if (issued_now) pc_reg = pc_reg + AW'(4);
    endtask

    task automatic clearStats();
        delivered    = 0;
        issued       = 0;
        stall_cycles = 0;
    endtask

    initial begin
        int max_run;
        int run;
        checks_done    = 0;
        fail_count     = 0;
        model_inflight = 1'b0;
        model_pending  = '0;
        dropped_pc     = 14'h3FFF;
        seen_dropped   = 0;
        first_pop_pc   = '0;
        last_pop_pc    = '0;
        clearStats();
        rst = 1'b1; chip_enable = 1'b0; pc = '0; flush = 1'b0; id_ready = 1'b0;

        // Reset release followed by three sequential fetches
        repeat (3) applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1);
        pc_reg = '0;
        clearStats();
        repeat (3) stepPc(1'b1, 1'b1);
        repeat (3) stepPc(1'b0, 1'b1);
        checkOutput("reset_seq_count", 32'(delivered), 32'd3);
        checkOutput("reset_seq_first", 32'(first_pop_pc), 32'h0000);
        checkOutput("reset_seq_last",  32'(last_pop_pc), 32'h0008);

        // Backpressure: only two words may be accepted, then the buffer drains in order
        clearStats();
        repeat (6) stepPc(1'b1, 1'b0);
        checkOutput("bp_issued", 32'(issued), 32'd2);
        checkOutput("bp_stall_cycles", 32'(stall_cycles), 32'd4);
        clearStats();
        repeat (4) stepPc(1'b0, 1'b1);
        checkOutput("bp_drained", 32'(delivered), 32'd2);

        // Flush while the buffer is full: the redirect target is the next word delivered
        repeat (4) stepPc(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 14'h0100, 1'b1, 1'b0);
        pc_reg = 14'h0100;
        clearStats();
        repeat (4) stepPc(1'b1, 1'b1);
        checkOutput("flush_next_pc", 32'(first_pop_pc), 32'h0100);

        // Flush during streaming, with a word returning and decode ready
        dropped_pc = pc_reg - AW'(4);
        applyStimulus(1'b0, 1'b1, pc_reg, 1'b1, 1'b1);
        checkOutput("flush_head_valid", 32'(obs_valid), 32'd1);
        pc_reg = 14'h0200;
        repeat (4) stepPc(1'b1, 1'b1);
        repeat (3) stepPc(1'b0, 1'b1);
        checkOutput("flush_dropped_seen", 32'(seen_dropped), 32'd0);
        dropped_pc = 14'h3FFF;

        // Misaligned PC
        applyStimulus(1'b0, 1'b1, 14'h0006, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("align_valid", 32'(obs_valid), 32'd1);
        checkOutput("align_fault", 32'(obs_fault), 32'(ALIGN_ON));
        checkOutput("align_out", obs_out, ALIGN_ON ? 32'h0 : rom_word(12'd1));
        repeat (2) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Streaming: 16 fetches with decode always ready
        pc_reg  = 14'h0040;
        clearStats();
        max_run = 0;
        run     = 0;
        for (int i = 0; i < 19; i++) begin
            stepPc(i < 16, 1'b1);
            run = obs_valid ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        checkOutput("stream_issued", 32'(issued), 32'd16);
        checkOutput("stream_delivered", 32'(delivered), 32'd16);
        checkOutput("stream_stalls", 32'(stall_cycles), 32'd0);
        checkOutput("stream_valid_run", 32'(max_run), 32'd16);

        // Randomized traffic including resets, flushes and misaligned PCs
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] rp;
            rp = AW'($urandom);
            if ($urandom_range(7) != 0) rp[1:0] = 2'b00;
            applyStimulus($urandom_range(63) == 0, $urandom_range(3) != 0, rp,
                          $urandom_range(9) == 0, $urandom_range(1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, fail_count);
        $finish;
    end

endmodule
